// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-input round-robin picker: on a tie the side not served last wins.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic    i_req,
    input  logic    d_req,
    input  req_id_t last_served,
    output logic    grant_c,
    output req_id_t winner_c
);

    always_comb begin
        grant_c  = i_req | d_req;
        winner_c = REQ_I;
        if (i_req && d_req) begin
            winner_c = (last_served == REQ_I) ? REQ_D : REQ_I;
        end else if (d_req) begin
            winner_c = REQ_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one memory port,
// with a bounded memory wait that aborts the transaction with bus_err.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned       MAX_WAIT = 16,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_rd_wr,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              bus_err
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    state_t           state;
    req_id_t          last_served;
    logic [CNT_W-1:0] wait_cnt;
    logic             err;
    logic             grant_c;
    req_id_t          winner_c;

    mem_arb_rr u_rr (
        .i_req       (i_req),
        .d_req       (d_req),
        .last_served (last_served),
        .grant_c     (grant_c),
        .winner_c    (winner_c)
    );

    // last_served also identifies the side being completed while in RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            last_served <= REQ_D;
            wait_cnt    <= '0;
            err         <= 1'b0;
            i_rdata     <= '0;
            d_rdata     <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_rd_wr   <= RD;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_c) begin
                        last_served <= winner_c;
                        wait_cnt    <= '0;
                        err         <= 1'b0;
                        if (winner_c == REQ_I) begin
                            state     <= BUSY_I;
                            mem_addr  <= i_addr;
                            mem_rd_wr <= RD;
                        end else begin
                            state     <= BUSY_D;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_rd_wr <= d_rd_wr;
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    // A completion on the timeout edge still counts as a success.
                    if (mem_ack) begin
                        state <= RESP;
                        if (state == BUSY_I) begin
                            i_rdata <= mem_rdata;
                        end else if (mem_rd_wr == RD) begin
                            d_rdata <= mem_rdata;
                        end
                    end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
                        state <= RESP;
                        err   <= 1'b1;
                        if (state == BUSY_I) begin
                            i_rdata <= ERR_DATA;
                        end else if (mem_rd_wr == RD) begin
                            d_rdata <= ERR_DATA;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshake outputs decoded straight from the registered state.
    always_comb begin
        mem_req = (state == BUSY_I) || (state == BUSY_D);
        i_ack   = (state == RESP) && (last_served == REQ_I);
        d_ack   = (state == RESP) && (last_served == REQ_D);
        bus_err = (state == RESP) && err;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 16, meaning memory-wait cycles allowed before a transaction is aborted with error.
REQ-002 SHALL have parameter ERR_DATA, default 32'h00000000, meaning the read data returned on an aborted transaction.
REQ-003 SHALL have these ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low.
- i_req  in  1  instruction-fetch request, held until i_ack.
- i_addr  in  32  fetch address.
- i_rdata  out  32  fetched word.
- i_ack  out  1  fetch complete, one-cycle pulse.
- d_req  in  1  data request, held until d_ack.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_rd_wr  in  1  1=read, 0=write.
- d_rdata  out  32  loaded word.
- d_ack  out  1  data complete, one-cycle pulse.
- mem_req  out  1  memory request.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rd_wr  out  1  1=read, 0=write.
- mem_rdata  in  32  memory read data.
- mem_ack  in  1  memory done, sampled on clk.
- bus_err  out  1  pulses with i_ack or d_ack when the transaction timed out.

Function
REQ-004 SHALL run an FSM with states IDLE, BUSY_I, BUSY_D and RESP.
REQ-005 In IDLE with only one request high, the FSM SHALL move to that requester's BUSY state on the next edge.
REQ-006 With both requests high in IDLE, SHALL grant round-robin: the requester not served last wins.
REQ-007 The last-served flag SHALL reset to "data", so the instruction side wins the first tie.
REQ-008 On grant, SHALL latch the address and, for BUSY_D, d_wdata and d_rd_wr; later requester input changes SHALL be ignored until the next IDLE.
REQ-009 For BUSY_I, mem_rd_wr SHALL be 1.
REQ-010 mem_req SHALL be 1 exactly while in a BUSY state; mem_addr, mem_wdata and mem_rd_wr SHALL stay stable throughout BUSY.
REQ-011 In BUSY, mem_ack=1 at an edge SHALL move the FSM to RESP and capture mem_rdata into i_rdata (BUSY_I) or d_rdata (BUSY_D read).
REQ-012 A write completion SHALL leave d_rdata unchanged.
REQ-013 A wait counter SHALL clear on entry to BUSY and increment each BUSY cycle with mem_ack=0.
REQ-014 When the wait counter reaches MAX_WAIT, SHALL go to RESP with the error flag set, drop mem_req, and load ERR_DATA into the read-data register only for reads.
REQ-015 When mem_ack and the timeout occur on the same edge, mem_ack SHALL win (no error).
REQ-016 In RESP, SHALL assert only the served side's ack for exactly one cycle, plus bus_err if errored, then return to IDLE on the next edge.
REQ-017 Requesters SHALL drop req on the edge that samples ack; the IDLE cycle after RESP therefore SHALL NOT re-grant the finished request.
REQ-018 Latency with zero-wait memory (mem_ack=1 in the first BUSY cycle): ack SHALL be high in the second cycle after the edge that sampled req, i.e. one IDLE-to-BUSY edge plus one BUSY-to-RESP edge.
REQ-019 A request arriving on the other side during BUSY or RESP SHALL wait, and SHALL be granted on the first IDLE edge.
REQ-020 Minimum spacing between grants SHALL be 3 cycles (BUSY, RESP, IDLE).

Reset
REQ-021 reset=0 SHALL immediately force state IDLE, mem_req=0, i_ack=0, d_ack=0, bus_err=0, i_rdata=0, d_rdata=0, mem_addr=0, mem_wdata=0, mem_rd_wr=1, wait counter=0, last-served=data.
REQ-022 Reset asserted mid-transaction SHALL abandon it with no ack; the first request after release SHALL be served normally.

Structure
REQ-023 Package mem_arb_pkg SHALL hold the FSM state enum, the requester-id enum (REQ_I, REQ_D) and the RD=1/WR=0 constants.
REQ-024 The tie-break SHALL live in sub-module mem_arb_rr: a two-input round-robin picker with the last-served flag as input.
REQ-025 Everything else SHALL be in one always_ff block plus combinational output decode.

Verification
REQ-026 Scenario: single fetch i_addr=32'h80020000 with mem_ack on the first BUSY cycle and mem_rdata=32'h27BDFFE8 -> i_ack high 2 cycles after the sampling edge, i_rdata=32'h27BDFFE8, d_ack=0.
REQ-027 Scenario: d write d_addr=32'h8011FFF0, d_wdata=32'hCAFEF00D, memory waits 3 cycles -> mem_req high 4 cycles with stable address/data and mem_rd_wr=0, then one d_ack pulse, d_rdata unchanged.
REQ-028 Scenario: i_req and d_req raised together twice in succession -> first grant to I, then D; on the repeat, I again, then D.
REQ-029 Scenario: mem_ack never asserted, MAX_WAIT=16, data read -> after 16 BUSY cycles d_ack=1, bus_err=1, d_rdata=ERR_DATA, mem_req=0.
REQ-030 Scenario: mem_ack on exactly the 16th wait edge -> normal completion, bus_err=0.
REQ-031 Scenario: reset pulsed low during BUSY_D -> mem_req=0 asynchronously, no d_ack; a new i_req after release completes with the normal latency.
